riscv_core_icache_refill_axi: RTL and testbench

//  Memory-side responder for the I-cache controller's refill request. Accepts a level-held request + address,

---
 rtl/riscv_core_axi_pkg.sv | 27 ++
 rtl/riscv_core_icache_refill_axi.sv | 179 +++++++++++++++++
 tb/tb_riscv_core_icache_refill_axi.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_axi_pkg.sv
// Shared AXI4 encodings and the I-cache refill state type used by the
// core's memory-side AXI responders.
package riscv_core_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Instruction fetch, secure, unprivileged
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;

  typedef enum logic [1:0] {
    REFILL_IDLE  = 2'd0,
    REFILL_AR    = 2'd1,
    REFILL_RDATA = 2'd2,
    REFILL_DONE  = 2'd3
  } refill_state_e;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not
  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/riscv_core_icache_refill_axi.sv
// I-cache line refill over one AXI4 INCR read burst: latch the line address,
// issue AR, assemble R beats into a line, pulse done.
// Optional ICACHE_REFILL_ERR_EN adds a sticky per-burst o_refill_err output.
module riscv_core_icache_refill_axi
  import riscv_core_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_line_data,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  output logic [2:0]                o_arprot,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
`ifdef ICACHE_REFILL_ERR_EN
  ,output logic                     o_refill_err
`endif
);

  localparam int BEATS       = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_WIDTH   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [2:0]           ARSIZE    = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  generate
    if ((LINE_WIDTH % AXI_DATA_WIDTH) != 0 || BEATS < 1) begin : g_bad_cfg
      $error("LINE_WIDTH must be a non-zero multiple of AXI_DATA_WIDTH");
    end
  endgenerate

  refill_state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:OFFSET_BITS]    addr_q, addr_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]              line_q, line_d;
  logic                               beat_acc_s;
  logic                               last_beat_s;

  assign beat_acc_s  = i_rvalid && (state_q == REFILL_RDATA);
  assign last_beat_s = (cnt_q == LAST_BEAT);

`ifdef ICACHE_REFILL_ERR_EN
  logic err_q, err_d;
  logic unused_s;
  assign unused_s     = ^{i_addr[OFFSET_BITS-1:0], i_rresp[0]};
  assign o_refill_err = err_q;
`else
  logic unused_s;
  assign unused_s = ^{i_addr[OFFSET_BITS-1:0], i_rresp, i_rlast};
`endif

  // State register and datapath flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= REFILL_IDLE;
      addr_q  <= {(ADDR_WIDTH - OFFSET_BITS){1'b0}};
      cnt_q   <= {CNT_WIDTH{1'b0}};
      line_q  <= {LINE_WIDTH{1'b0}};
`ifdef ICACHE_REFILL_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
`ifdef ICACHE_REFILL_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic; completion is counted, never taken from RLAST
  always_comb begin
    state_d = state_q;
    case (state_q)
      REFILL_IDLE: begin
        if (i_mem_req) state_d = REFILL_AR;
        else           state_d = REFILL_IDLE;
      end
      REFILL_AR: begin
        if (i_arready) state_d = REFILL_RDATA;
        else           state_d = REFILL_AR;
      end
      REFILL_RDATA: begin
        if (beat_acc_s && last_beat_s) state_d = REFILL_DONE;
        else                           state_d = REFILL_RDATA;
      end
      REFILL_DONE: state_d = REFILL_IDLE;
      default:     state_d = REFILL_IDLE;
    endcase
  end

  // Address latch, beat counter, line assembly and error accumulation
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    line_d = line_q;
`ifdef ICACHE_REFILL_ERR_EN
    err_d  = err_q;
`endif
    case (state_q)
      REFILL_IDLE: begin
        if (i_mem_req) begin
          addr_d = i_addr[ADDR_WIDTH-1:OFFSET_BITS];
          cnt_d  = {CNT_WIDTH{1'b0}};
`ifdef ICACHE_REFILL_ERR_EN
          err_d  = 1'b0;
`endif
        end else begin
          addr_d = addr_q;
        end
      end
      REFILL_RDATA: begin
        if (beat_acc_s) begin
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_WIDTH'(b)) begin
              line_d[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_rdata;
            end else begin
              line_d[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = line_q[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
          end
          cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef ICACHE_REFILL_ERR_EN
          err_d = err_q | axi_resp_is_err(i_rresp) | (i_rlast != last_beat_s);
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Handshake outputs decoded straight from the state flop
  always_comb begin
    o_arvalid  = 1'b0;
    o_rready   = 1'b0;
    o_mem_done = 1'b0;
    case (state_q)
      REFILL_AR:    o_arvalid  = 1'b1;
      REFILL_RDATA: o_rready   = 1'b1;
      REFILL_DONE:  o_mem_done = 1'b1;
      default: begin
        o_arvalid  = 1'b0;
        o_rready   = 1'b0;
        o_mem_done = 1'b0;
      end
    endcase
  end

  assign o_line_data = line_q;
  assign o_araddr    = {addr_q, {OFFSET_BITS{1'b0}}};
  assign o_arlen     = 8'(BEATS - 1);
  assign o_arsize    = ARSIZE;
  assign o_arburst   = AXI_BURST_INCR;
  assign o_arid      = AXI_ID_WIDTH'(AXI_ID);
  assign o_arprot    = AXI_PROT_INSTR;

endmodule

// File: tb/tb_riscv_core_icache_refill_axi.sv
// Directed bench for riscv_core_icache_refill_axi: reset, single refill,
// AR stall, R gaps, request drop, mid-burst reset and (optionally) errors.
module tb_riscv_core_icache_refill_axi;

  localparam int AW = 64;
  localparam int LW = 256;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_mem_req;
  logic [AW-1:0] i_addr;
  logic          o_mem_done;
  logic [LW-1:0] o_line_data;
  logic          o_arvalid;
  logic          i_arready;
  logic [AW-1:0] o_araddr;
  logic [7:0]    o_arlen;
  logic [2:0]    o_arsize;
  logic [1:0]    o_arburst;
  logic [IW-1:0] o_arid;
  logic [2:0]    o_arprot;
  logic          i_rvalid;
  logic          o_rready;
  logic [DW-1:0] i_rdata;
  logic [1:0]    i_rresp;
  logic          i_rlast;
`ifdef ICACHE_REFILL_ERR_EN
  logic          o_refill_err;
`endif

  always #5 clk = ~clk;

  riscv_core_icache_refill_axi dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mem_req   (i_mem_req),
    .i_addr      (i_addr),
    .o_mem_done  (o_mem_done),
    .o_line_data (o_line_data),
    .o_arvalid   (o_arvalid),
    .i_arready   (i_arready),
    .o_araddr    (o_araddr),
    .o_arlen     (o_arlen),
    .o_arsize    (o_arsize),
    .o_arburst   (o_arburst),
    .o_arid      (o_arid),
    .o_arprot    (o_arprot),
    .i_rvalid    (i_rvalid),
    .o_rready    (o_rready),
    .i_rdata     (i_rdata),
    .i_rresp     (i_rresp),
    .i_rlast     (i_rlast)
`ifdef ICACHE_REFILL_ERR_EN
    ,.o_refill_err(o_refill_err)
`endif
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] beats [4];
  int n_acc;
  int resp_err_idx = -1;
  int rlast_idx = 3;
  int done_cyc;
  int ndone;

  function automatic logic [LW-1:0] exp_line();
    return {beats[3], beats[2], beats[1], beats[0]};
  endfunction

  // Drive one R-channel cycle for the next edge, then advance to the following negedge
  task automatic step(input logic rv);
    logic acc;
    i_rvalid = rv;
    if (rv && n_acc < 4) begin
      i_rdata = beats[n_acc];
      i_rlast = (n_acc == rlast_idx);
      i_rresp = (n_acc == resp_err_idx) ? 2'b10 : 2'b00;
    end else begin
      i_rdata = POISON;
      i_rlast = 1'b0;
      i_rresp = 2'b00;
    end
    acc = rv && o_rready;
    @(negedge clk);
    if (acc) n_acc++;
  endtask

  task automatic start_req(input logic [AW-1:0] a);
    n_acc = 0;
    done_cyc = -1;
    ndone = 0;
    i_mem_req = 1'b1;
    i_addr = a;
  endtask

  task automatic note_done(input int c);
    if (o_mem_done) begin
      ndone++;
      if (done_cyc < 0) done_cyc = c;
      i_mem_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_mem_req = 1'b0; i_addr = '0; i_arready = 1'b0;
    i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_rlast = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({o_arvalid, o_rready, o_mem_done} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 000", {o_arvalid, o_rready, o_mem_done});
    end
    tests++;
    if (o_line_data !== {LW{1'b0}}) begin
      fails++; $display("FAIL reset_line: got %h expected 0", o_line_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (o_arvalid !== 1'b0) begin
      fails++; $display("FAIL idle_no_req: arvalid got %b expected 0", o_arvalid);
    end
  endtask

  task automatic test_basic();
    beats = '{64'h0000_0000_AAAA_0000, 64'h1111_1111_AAAA_0001,
              64'h2222_2222_AAAA_0002, 64'h3333_3333_AAAA_0003};
    i_arready = 1'b1;
    start_req(64'h0000_0000_8000_1234);
    for (int c = 1; c <= 12; c++) begin
      step(1'b1);
      if (c == 1) begin
        tests++;
        if (o_araddr !== 64'h0000_0000_8000_1220 || o_arvalid !== 1'b1) begin
          fails++; $display("FAIL basic_araddr: got %h/%b expected 80001220/1", o_araddr, o_arvalid);
        end
        tests++;
        if ({o_arlen, o_arsize, o_arburst, o_arid, o_arprot} !== {8'd3, 3'd3, 2'b01, 4'd0, 3'b100}) begin
          fails++; $display("FAIL basic_arfields: got len=%0d size=%0d burst=%0d id=%0d prot=%b expected 3 3 1 0 100",
                            o_arlen, o_arsize, o_arburst, o_arid, o_arprot);
        end
        tests++;
        if (o_rready !== 1'b0) begin
          fails++; $display("FAIL basic_rready_in_ar: got %b expected 0", o_rready);
        end
      end
      note_done(c);
    end
    tests++;
    if (done_cyc != 6 || ndone != 1) begin
      fails++; $display("FAIL basic_done: got cycle %0d count %0d expected 6 1", done_cyc, ndone);
    end
    tests++;
    if (o_line_data !== exp_line()) begin
      fails++; $display("FAIL basic_line: got %h expected %h", o_line_data, exp_line());
    end
  endtask

  task automatic test_arready_stall();
    int stable;
    stable = 0;
    beats = '{64'hB0B0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
              64'hB2B2_0000_0000_0003, 64'hB3B3_0000_0000_0004};
    i_arready = 1'b0;
    start_req(64'h0000_0000_0000_1FFF);
    for (int c = 1; c <= 16; c++) begin
      step(1'b1);
      if (c <= 5 && o_arvalid === 1'b1 && o_araddr === 64'h0000_0000_0000_1FE0 && o_rready === 1'b0)
        stable++;
      if (c == 6) i_arready = 1'b1;
      note_done(c);
    end
    tests++;
    if (stable != 5) begin
      fails++; $display("FAIL stall_ar_stable: got %0d stable cycles expected 5", stable);
    end
    tests++;
    if (done_cyc != 11 || ndone != 1) begin
      fails++; $display("FAIL stall_done: got cycle %0d count %0d expected 11 1", done_cyc, ndone);
    end
    tests++;
    if (o_line_data !== exp_line()) begin
      fails++; $display("FAIL stall_line: got %h expected %h", o_line_data, exp_line());
    end
  endtask

  task automatic test_rvalid_gaps();
    logic pat [7];
    logic rv;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    beats = '{64'hC000_0000_0000_00C0, 64'hC111_0000_0000_00C1,
              64'hC222_0000_0000_00C2, 64'hC333_0000_0000_00C3};
    i_arready = 1'b1;
    start_req(64'h0000_0001_0000_0020);
    for (int c = 1; c <= 16; c++) begin
      if (c < 3)       rv = 1'b0;
      else if (c <= 9) rv = pat[c-3];
      else             rv = 1'b1;
      step(rv);
      note_done(c);
    end
    tests++;
    if (done_cyc != 9 || ndone != 1) begin
      fails++; $display("FAIL gaps_done: got cycle %0d count %0d expected 9 1", done_cyc, ndone);
    end
    tests++;
    if (n_acc != 4) begin
      fails++; $display("FAIL gaps_beats: got %0d accepted beats expected 4", n_acc);
    end
    tests++;
    if (o_line_data !== exp_line()) begin
      fails++; $display("FAIL gaps_line: got %h expected %h", o_line_data, exp_line());
    end
  endtask

  task automatic test_req_drop();
    beats = '{64'hD0D0_D0D0_0000_0000, 64'hD1D1_D1D1_0000_0001,
              64'hD2D2_D2D2_0000_0002, 64'hD3D3_D3D3_0000_0003};
    i_arready = 1'b0;
    start_req(64'h0000_0000_1234_5678);
    for (int c = 1; c <= 14; c++) begin
      step(1'b1);
      if (c == 1) begin
        i_mem_req = 1'b0;
        i_addr = 64'h0000_0000_0000_0040;
      end
      if (c == 2) begin
        tests++;
        if (o_araddr !== 64'h0000_0000_1234_5660 || o_arvalid !== 1'b1) begin
          fails++; $display("FAIL drop_araddr: got %h/%b expected 12345660/1", o_araddr, o_arvalid);
        end
        i_arready = 1'b1;
      end
      note_done(c);
    end
    tests++;
    if (done_cyc != 7 || ndone != 1) begin
      fails++; $display("FAIL drop_done: got cycle %0d count %0d expected 7 1", done_cyc, ndone);
    end
    tests++;
    if (o_line_data !== exp_line() || o_arvalid !== 1'b0) begin
      fails++; $display("FAIL drop_line: got %h arvalid %b expected %h 0", o_line_data, o_arvalid, exp_line());
    end
  endtask

  task automatic test_reset_mid_burst();
    beats = '{64'hE0E0_0000_0000_0000, 64'hE1E1_0000_0000_0001,
              64'hE2E2_0000_0000_0002, 64'hE3E3_0000_0000_0003};
    i_arready = 1'b1;
    start_req(64'h0000_0000_0000_2000);
    for (int c = 1; c <= 4; c++) step(1'b1);
    tests++;
    if (n_acc != 2 || o_rready !== 1'b1) begin
      fails++; $display("FAIL rst_pre: got beats %0d rready %b expected 2 1", n_acc, o_rready);
    end
    rst_n = 1'b0;
    i_mem_req = 1'b0;
    #1;
    tests++;
    if ({o_arvalid, o_rready, o_mem_done} !== 3'b000 || o_line_data !== {LW{1'b0}}) begin
      fails++; $display("FAIL rst_mid: got ctrl %b line %h expected 000 0",
                        {o_arvalid, o_rready, o_mem_done}, o_line_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    beats = '{64'hF0F0_0000_0000_0010, 64'hF1F1_0000_0000_0011,
              64'hF2F2_0000_0000_0012, 64'hF3F3_0000_0000_0013};
    start_req(64'h0000_0000_0000_3047);
    for (int c = 1; c <= 10; c++) begin
      step(1'b1);
      if (c == 1) begin
        tests++;
        if (o_araddr !== 64'h0000_0000_0000_3040) begin
          fails++; $display("FAIL rst_new_araddr: got %h expected 3040", o_araddr);
        end
      end
      note_done(c);
    end
    tests++;
    if (done_cyc != 6 || ndone != 1 || o_line_data !== exp_line()) begin
      fails++; $display("FAIL rst_new_burst: got cycle %0d count %0d line %h expected 6 1 %h",
                        done_cyc, ndone, o_line_data, exp_line());
    end
  endtask

`ifdef ICACHE_REFILL_ERR_EN
  task automatic test_err();
    logic err_at_done;
    beats = '{64'h5000_0000_0000_0000, 64'h5001_0000_0000_0000,
              64'h5002_0000_0000_0000, 64'h5003_0000_0000_0000};
    i_arready = 1'b1;
    resp_err_idx = 1;
    err_at_done = 1'b0;
    start_req(64'h0000_0000_0000_4000);
    for (int c = 1; c <= 10; c++) begin
      step(1'b1);
      if (o_mem_done) err_at_done = o_refill_err;
      note_done(c);
    end
    tests++;
    if (ndone != 1 || err_at_done !== 1'b1 || o_refill_err !== 1'b1) begin
      fails++; $display("FAIL err_resp: got done %0d err %b held %b expected 1 1 1", ndone, err_at_done, o_refill_err);
    end
    resp_err_idx = -1;
    err_at_done = 1'b1;
    start_req(64'h0000_0000_0000_5000);
    for (int c = 1; c <= 10; c++) begin
      step(1'b1);
      if (c == 1) begin
        tests++;
        if (o_refill_err !== 1'b0) begin
          fails++; $display("FAIL err_clear: got %b expected 0", o_refill_err);
        end
      end
      if (o_mem_done) err_at_done = o_refill_err;
      note_done(c);
    end
    tests++;
    if (ndone != 1 || err_at_done !== 1'b0) begin
      fails++; $display("FAIL err_clean: got done %0d err %b expected 1 0", ndone, err_at_done);
    end
    rlast_idx = 2;
    err_at_done = 1'b0;
    start_req(64'h0000_0000_0000_6000);
    for (int c = 1; c <= 10; c++) begin
      step(1'b1);
      if (o_mem_done) err_at_done = o_refill_err;
      note_done(c);
    end
    rlast_idx = 3;
    tests++;
    if (ndone != 1 || err_at_done !== 1'b1 || o_line_data !== exp_line()) begin
      fails++; $display("FAIL err_rlast: got done %0d err %b line %h expected 1 1 %h",
                        ndone, err_at_done, o_line_data, exp_line());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_arready_stall();
    test_rvalid_gaps();
    test_req_drop();
    test_reset_mid_burst();
`ifdef ICACHE_REFILL_ERR_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
